// File: rtl/pipe_pkg.sv
// Shared definitions for the CPU inter-stage pipeline registers: cause codes,
// default field widths and the slot-update priority encoding.
package pipe_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int PC_W_DEF    = 32;
  localparam int CAUSE_W_DEF = 5;
  localparam int CNT_W_DEF   = 16;

  localparam logic [4:0] CAUSE_NONE = 5'd0;
  localparam logic [4:0] CAUSE_INT  = 5'd0;
  localparam logic [4:0] CAUSE_ADEL = 5'd4;
  localparam logic [4:0] CAUSE_ADES = 5'd5;
  localparam logic [4:0] CAUSE_RI   = 5'd10;
  localparam logic [4:0] CAUSE_OV   = 5'd12;

  typedef enum logic [2:0] {
    EXC,
    STALL,
    FLUSH,
    HOLD,
    LOAD
  } slot_op_e;

  // Resolves the competing slot controls; earlier tests win.
  function automatic slot_op_e slot_op(input logic exc_flush,
                                       input logic stall,
                                       input logic flush,
                                       input logic backpressure);
    if (exc_flush)         return EXC;
    else if (stall)        return STALL;
    else if (flush)        return FLUSH;
    else if (backpressure) return HOLD;
    else                   return LOAD;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry (valid, pc, payload, cause) with clear/load/hold control.
// Invalid entries are always stored with zero payload and cause.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CAUSE_W = CAUSE_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               load,
  input  logic               d_valid,
  input  logic [PC_W-1:0]    d_pc,
  input  logic [DATA_W-1:0]  d_data,
  input  logic [CAUSE_W-1:0] d_cause,
  output logic               q_valid,
  output logic [PC_W-1:0]    q_pc,
  output logic [DATA_W-1:0]  q_data,
  output logic [CAUSE_W-1:0] q_cause
);

  // A clear still captures the PC so an exception flush can keep it for EPC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_valid <= 1'b0;
      q_pc    <= '0;
      q_data  <= '0;
      q_cause <= '0;
    end else if (clr) begin
      q_valid <= 1'b0;
      q_pc    <= d_pc;
      q_data  <= '0;
      q_cause <= '0;
    end else if (load) begin
      q_valid <= d_valid;
      q_pc    <= d_pc;
      q_data  <= d_valid ? d_data : '0;
      q_cause <= d_valid ? d_cause : '0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with flush/stall/backpressure priority and a
// saturating hold counter. Define PIPE_SKID_EN for a skid slot and registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int PC_W    = PC_W_DEF,
  parameter int CAUSE_W = CAUSE_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [CAUSE_W-1:0] in_cause,
  input  logic               stall,
  input  logic               flush,
  input  logic               exc_flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [DATA_W-1:0]  out_data,
  output logic [CAUSE_W-1:0] out_cause,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   hold_cnt
);

  slot_op_e           op;
  logic               holding;
  logic               m_valid;
  logic [PC_W-1:0]    m_pc;
  logic [DATA_W-1:0]  m_data;
  logic [CAUSE_W-1:0] m_cause;

  always_comb begin
    op      = slot_op(exc_flush, stall, flush, out_valid && !out_ready);
    holding = (op == STALL) || (op == HOLD);
  end

`ifdef PIPE_SKID_EN
  logic               ready_q;
  logic               in_fire;
  logic               use_skid;
  logic               skid_valid;
  logic [PC_W-1:0]    skid_pc;
  logic [DATA_W-1:0]  skid_data;
  logic [CAUSE_W-1:0] skid_cause;

  // ready_q keeps in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ready_q <= 1'b0;
    else      ready_q <= 1'b1;
  end

  assign in_ready = ready_q && !skid_valid;
  assign in_fire  = in_valid && in_ready;
  assign use_skid = skid_valid && (op == LOAD);
  assign m_valid  = use_skid ? 1'b1 : in_fire;
  assign m_pc     = use_skid ? skid_pc : in_pc;
  assign m_data   = use_skid ? skid_data : in_data;
  assign m_cause  = use_skid ? skid_cause : in_cause;

  // The skid empties on any non-holding edge: flushed, or handed to the main slot.
  pipe_slot #(
    .PC_W   (PC_W),
    .DATA_W (DATA_W),
    .CAUSE_W(CAUSE_W)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .clr    (!holding),
    .load   (in_fire && holding),
    .d_valid(in_valid),
    .d_pc   (in_pc),
    .d_data (in_data),
    .d_cause(in_cause),
    .q_valid(skid_valid),
    .q_pc   (skid_pc),
    .q_data (skid_data),
    .q_cause(skid_cause)
  );
`else
  assign in_ready = !stall && (!out_valid || out_ready);
  assign m_valid  = in_valid;
  assign m_pc     = in_pc;
  assign m_data   = in_data;
  assign m_cause  = in_cause;
`endif

  pipe_slot #(
    .PC_W   (PC_W),
    .DATA_W (DATA_W),
    .CAUSE_W(CAUSE_W)
  ) u_main (
    .clk    (clk),
    .rst    (rst),
    .clr    ((op == EXC) || (op == FLUSH)),
    .load   (op == LOAD),
    .d_valid(m_valid),
    .d_pc   (m_pc),
    .d_data (m_data),
    .d_cause(m_cause),
    .q_valid(out_valid),
    .q_pc   (out_pc),
    .q_data (out_data),
    .q_cause(out_cause)
  );

  // Counts cycles a valid entry sits still; clear beats increment, never wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt <= '0;
    end else if (cnt_clr) begin
      hold_cnt <= '0;
    end else if (out_valid && holding && (hold_cnt != '1)) begin
      hold_cnt <= hold_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg in its default build (PIPE_SKID_EN undefined),
// with a narrow hold counter so saturation is reachable.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic [4:0]  cause;
  } entry_t;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_pc;
  logic [31:0]      in_data;
  logic [4:0]       in_cause;
  logic             stall;
  logic             flush;
  logic             exc_flush;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_pc;
  logic [31:0]      out_data;
  logic [4:0]       out_cause;
  logic             cnt_clr;
  logic [CNT_W-1:0] hold_cnt;

  int               vectors = 0;
  int               miscompares = 0;
  entry_t           expq[$];
  logic [31:0]      bubblePc;
  logic [CNT_W-1:0] expCnt;
  bit               done;

  pipe_stage_reg #(
    .DATA_W (32),
    .PC_W   (32),
    .CAUSE_W(5),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_pc    (in_pc),
    .in_data  (in_data),
    .in_cause (in_cause),
    .stall    (stall),
    .flush    (flush),
    .exc_flush(exc_flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc   (out_pc),
    .out_data (out_data),
    .out_cause(out_cause),
    .cnt_clr  (cnt_clr),
    .hold_cnt (hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic driveIdle();
    in_valid  = 1'b0;
    in_pc     = '0;
    in_data   = '0;
    in_cause  = '0;
    stall     = 1'b0;
    flush     = 1'b0;
    exc_flush = 1'b0;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
  endtask

  task automatic doReset(input int cycles);
    @(negedge clk);
    rst = 1'b0;
    driveIdle();
    expq.delete();
    expCnt   = '0;
    bubblePc = '0;
    #1;
    checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_out_pc", 64'(out_pc), 64'(0));
    checkOutput("rst_out_data", 64'(out_data), 64'(0));
    checkOutput("rst_out_cause", 64'(out_cause), 64'(0));
    checkOutput("rst_hold_cnt", 64'(hold_cnt), 64'(0));
    repeat (cycles) @(negedge clk);
    rst = 1'b1;
  endtask

  // One clock of stimulus; the reference model is advanced at the edge.
  task automatic applyStimulus(input bit iv, input logic [31:0] pc, input logic [31:0] data,
                               input logic [4:0] cause, input bit st, input bit fl,
                               input bit ex, input bit ordy, input bit clr);
    bit expReady;
    bit validBefore;
    @(negedge clk);
    in_valid  = iv;
    in_pc     = pc;
    in_data   = data;
    in_cause  = cause;
    stall     = st;
    flush     = fl;
    exc_flush = ex;
    out_ready = ordy;
    cnt_clr   = clr;
    #1;
    validBefore = (expq.size() != 0);
    expReady    = !st && (!validBefore || ordy);
    checkOutput("in_ready", 64'(in_ready), 64'(expReady));
    @(posedge clk);
    if (clr)
      expCnt = '0;
    else if (validBefore && ((st && !ex) || (!st && !fl && !ex && !ordy)) && expCnt != CNT_MAX)
      expCnt = expCnt + 1'b1;
    if (ex || (fl && !st)) begin
      expq.delete();
      bubblePc = pc;
    end else if (expReady) begin
      if (iv) expq.push_back('{pc: pc, data: data, cause: cause});
      else    bubblePc = pc;
    end
    #1;
    checkOutput("hold_cnt", 64'(hold_cnt), 64'(expCnt));
    checkOutput("out_valid", 64'(out_valid), 64'(expq.size() != 0));
    if (expq.size() == 0) begin
      checkOutput("bubble_pc", 64'(out_pc), 64'(bubblePc));
      checkOutput("bubble_data", 64'(out_data), 64'(0));
      checkOutput("bubble_cause", 64'(out_cause), 64'(0));
    end
  endtask

  // Monitor: compares every presented entry with the scoreboard head and
  // retires it on the edge where it actually leaves the stage.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst && !done && out_valid) begin
        if (expq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL out_entry: got out_valid=1, expected no entry");
        end else begin
          checkOutput("out_pc", 64'(out_pc), 64'(expq[0].pc));
          checkOutput("out_data", 64'(out_data), 64'(expq[0].data));
          checkOutput("out_cause", 64'(out_cause), 64'(expq[0].cause));
          if (out_ready && !stall) void'(expq.pop_front());
        end
      end
    end
  end

  initial begin
    done     = 1'b0;
    rst      = 1'b0;
    expCnt   = '0;
    bubblePc = '0;
    driveIdle();
    doReset(2);

    // Back-to-back stream, then drain.
    applyStimulus(1, 32'h3000, 32'h1111, CAUSE_NONE, 0, 0, 0, 1, 0);
    applyStimulus(1, 32'h3004, 32'h2222, CAUSE_NONE, 0, 0, 0, 1, 0);
    applyStimulus(0, 32'h0, 32'h0, CAUSE_NONE, 0, 0, 0, 1, 0);

    // Stall holds C for three cycles while D waits upstream.
    applyStimulus(1, 32'h3010, 32'hCCCC, CAUSE_NONE, 0, 0, 0, 1, 0);
    repeat (3) applyStimulus(1, 32'h3014, 32'hDDDD, CAUSE_NONE, 1, 0, 0, 1, 0);
    applyStimulus(1, 32'h3014, 32'hDDDD, CAUSE_NONE, 0, 0, 0, 1, 0);
    applyStimulus(0, 32'h0, 32'h0, CAUSE_NONE, 0, 0, 0, 1, 0);

    // Bubble flush, then flush under stall, then exception flush under stall.
    applyStimulus(1, 32'h3008, 32'h3333, CAUSE_RI, 0, 1, 0, 1, 0);
    applyStimulus(1, 32'h3020, 32'hEEEE, CAUSE_ADEL, 0, 0, 0, 1, 0);
    applyStimulus(1, 32'h3024, 32'h4444, CAUSE_NONE, 1, 1, 0, 1, 0);
    applyStimulus(1, 32'h4000, 32'h5555, CAUSE_OV, 1, 0, 1, 0, 0);

    // Long backpressure saturates the counter; clear during the hold.
    applyStimulus(1, 32'h3030, 32'hF0F0, CAUSE_ADES, 0, 0, 0, 0, 0);
    repeat (20) applyStimulus(0, 32'h0, 32'h0, CAUSE_NONE, 0, 0, 0, 0, 0);
    applyStimulus(0, 32'h0, 32'h0, CAUSE_NONE, 0, 0, 0, 0, 1);
    applyStimulus(0, 32'h0, 32'h0, CAUSE_NONE, 0, 0, 0, 0, 0);
    applyStimulus(0, 32'h0, 32'h0, CAUSE_NONE, 0, 0, 0, 1, 0);

    // Random traffic, a reset in the middle of the stream, more random traffic.
    for (int i = 0; i < 300; i++)
      applyStimulus($urandom_range(0, 9) < 7, $urandom, $urandom, 5'($urandom),
                    $urandom_range(0, 19) < 3, $urandom_range(0, 19) < 1,
                    $urandom_range(0, 39) < 1, $urandom_range(0, 9) < 7,
                    $urandom_range(0, 29) < 1);
    doReset(1);
    for (int i = 0; i < 200; i++)
      applyStimulus($urandom_range(0, 9) < 7, $urandom, $urandom, 5'($urandom),
                    $urandom_range(0, 19) < 3, $urandom_range(0, 19) < 1,
                    $urandom_range(0, 39) < 1, $urandom_range(0, 9) < 7,
                    $urandom_range(0, 29) < 1);
    repeat (3) applyStimulus(0, 32'h0, 32'h0, CAUSE_NONE, 0, 0, 0, 1, 0);

    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
